quant_ctrl: RTL and testbench
=============================

Name: quant_ctrl

Overview:
Sequencer wrapped around the combinational 8x8 quantizer. Accepts DCT coefficients (Y/Cb/Cr per beat, raster order) over valid/ready. Drives quantizer data plus row/column index, registers quantized results, and delivers them downstream to zig-zag/entropy coding with block framing flags. Also handles quantizer table-load reset, block-alignment checking and flush.

Parameters:
CW, 14, input coefficient width (signed, two's complement)
QW, 10, quantized output width (signed)
BLK_W, 16, completed-block counter width

Ports:
clk  in  1  clock, all logic rising-edge
reset  in  1  reset, synchronous, active-high
flush  in  1  sync: drop in-flight data, restart at coefficient 0
err_clr  in  1  clears sync_err
in_valid  in  1  input beat valid
in_ready  out  1  controller accepts beat
in_y, in_cb, in_cr  in  CW each  DCT coefficients
in_last  in  1  upstream marks coefficient 63
q_reset  out  1  quantizer table-load reset
q_y_in, q_cb_in, q_cr_in  out  CW each  to quantizer
q_x, q_y  out  3 each  row, column index (quantizer index = 8*q_x+q_y)
q_y_out, q_cb_out, q_cr_out  in  QW each  from quantizer (combinational)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_y, out_cb, out_cr  out  QW each  quantized coefficients
out_first  out  1  coefficient 0 of block
out_last  out  1  coefficient 63 of block
blk_cnt  out  BLK_W  completed blocks delivered, wraps
sync_err  out  1  sticky in_last misalignment flag

Behaviour:
- FSM: INIT -> RUN. reset forces INIT; INIT lasts exactly 1 cycle after reset deasserts, then RUN.
- q_reset = 1 while reset high and during INIT; 0 in RUN. in_ready = 0 in reset/INIT.
- Reset values: out_valid 0, all data outputs 0, out_first/out_last 0, blk_cnt 0, sync_err 0, position 0, q_x/q_y 0, stage valids 0.
- Pipeline: S0 (input register: data, row, col, first, last) drives q_* outputs; S1 (output register) captures q_*_out plus S0 flags.
- Stage advance: S1 loads when S0 valid and (!S1 valid or out_ready). S0 loads when in_valid and in_ready.
- in_ready (RUN) = !S0 valid or S1 loads this cycle. Full throughput 1 beat/cycle with no back-pressure.
- Latency: beat accepted in cycle N appears on out_* in cycle N+2 (out_valid high), absent stalls.
- out_* held stable while out_valid and !out_ready. No beat dropped or duplicated.
- Position: 6-bit counter, row = pos[5:3], col = pos[2:0]; increments per accepted beat, 63 -> 0.
- out_first = (pos==0) and out_last = (pos==63), from internal counter, not in_last.
- Alignment check on accepted beat:
  - in_last=1, pos!=63: set sync_err; beat is marked last; counter -> 0.
  - in_last=0, pos==63: set sync_err; counter wraps normally.
- blk_cnt increments on out_valid & out_ready & out_last; wraps at 2^BLK_W.
- err_clr clears sync_err; a simultaneous set wins.
- flush: next cycle S0/S1 valid = 0 and pos = 0; blk_cnt and sync_err kept. A beat offered in the flush cycle is dropped (in_ready=0 that cycle).
- reset mid-block: everything returns to reset values and INIT; the partial block is discarded.
- Quantizer results are sampled only when S0 valid; the arithmetic is owned by the quantizer.

Decomposition:
- Shared package jpeg_pkg: CW/QW constants, BLK_SIZE=64, coefficient and quantized-coefficient typedefs, pos_t (6-bit), FSM state enum.
- Single module; no sub-module needed. Optional instance of the quantizer lives in the parent, not inside quant_ctrl.

Test Plan:
- Reset release: q_reset high through reset plus 1 cycle, in_ready=0 then 1. 64 beats in_y=k, out_ready=1 -> outputs in order 2 cycles later, q_x/q_y = 0,0 .. 7,7, out_first on beat 0, out_last on beat 63, blk_cnt=1.
- Back-pressure: out_ready toggles 1,0,0,1 over 3 blocks -> every beat delivered exactly once, out_* stable during stalls, blk_cnt=3, in_ready low only while S0 and S1 are both full.
- Early last: in_last on beat 40 -> sync_err=1, beat 40 has out_last=1, next beat row/col=0,0; err_clr pulse -> sync_err=0.
- Missing last: beat 63 with in_last=0 -> sync_err=1, framing unchanged (next beat first).
- Flush at beat 20 with both stages full -> out_valid=0 next cycle, next accepted beat has q_x=0, q_y=0, blk_cnt unchanged.
- Reset at beat 30 -> outputs zero, INIT cycle with q_reset=1, then fresh block starts at position 0.

Source files
------------

// File: rtl/jpeg_pkg.sv
// Shared JPEG pipeline types: coefficient widths, block geometry and the quantizer-sequencer states.
package jpeg_pkg;
  localparam int CW       = 14;
  localparam int QW       = 10;
  localparam int BLK_SIZE = 64;

  typedef logic signed [CW-1:0] coef_t;
  typedef logic signed [QW-1:0] qcoef_t;
  typedef logic [5:0]           pos_t;

  typedef enum logic {ST_INIT, ST_RUN} state_t;
endpackage

// File: rtl/quant_ctrl.sv
// Quantizer sequencer: indexes the 8x8 quantizer per coefficient and frames blocks; 2-cycle latency.
// Two-entry pipeline; in_ready drops only while both stages are full and downstream stalls.
module quant_ctrl #(
  parameter int CW    = jpeg_pkg::CW,
  parameter int QW    = jpeg_pkg::QW,
  parameter int BLK_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 err_clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [CW-1:0] in_y,
  input  logic signed [CW-1:0] in_cb,
  input  logic signed [CW-1:0] in_cr,
  input  logic                 in_last,
  output logic                 q_reset,
  output logic signed [CW-1:0] q_y_in,
  output logic signed [CW-1:0] q_cb_in,
  output logic signed [CW-1:0] q_cr_in,
  output logic [2:0]           q_x,
  output logic [2:0]           q_y,
  input  logic signed [QW-1:0] q_y_out,
  input  logic signed [QW-1:0] q_cb_out,
  input  logic signed [QW-1:0] q_cr_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [QW-1:0] out_y,
  output logic signed [QW-1:0] out_cb,
  output logic signed [QW-1:0] out_cr,
  output logic                 out_first,
  output logic                 out_last,
  output logic [BLK_W-1:0]     blk_cnt,
  output logic                 sync_err
);
  import jpeg_pkg::*;

  localparam pos_t LAST_POS = pos_t'(BLK_SIZE - 1);

  state_t state, state_nxt;
  logic   run;

  pos_t                 pos;
  pos_t                 s0_pos;
  logic                 s0_vld, s0_first, s0_last;
  logic signed [CW-1:0] s0_y, s0_cb, s0_cr;
  logic                 s1_vld;

  logic in_fire, s1_load, out_fire, pos_is_last, align_err;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    run       = 1'b0;
    case (state)
      ST_INIT: state_nxt = ST_RUN;
      ST_RUN:  run = 1'b1;
    endcase
  end

  assign q_reset     = reset | ~run;
  assign s1_load     = s0_vld & (~s1_vld | out_ready);
  assign in_ready    = run & ~reset & ~flush & (~s0_vld | s1_load);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = s1_vld & out_ready;
  assign out_valid   = s1_vld;
  assign pos_is_last = (pos == LAST_POS);
  // Framing comes from our own counter; upstream in_last only checks alignment (or forces an early end).
  assign align_err   = in_fire & (in_last ^ pos_is_last);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      pos <= '0;
    end else if (in_fire) begin
      pos <= in_last ? '0 : pos + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld   <= 1'b0;
      s0_y     <= '0;
      s0_cb    <= '0;
      s0_cr    <= '0;
      s0_pos   <= '0;
      s0_first <= 1'b0;
      s0_last  <= 1'b0;
    end else begin
      if (flush)        s0_vld <= 1'b0;
      else if (in_fire) s0_vld <= 1'b1;
      else if (s1_load) s0_vld <= 1'b0;
      if (in_fire) begin
        s0_y     <= in_y;
        s0_cb    <= in_cb;
        s0_cr    <= in_cr;
        s0_pos   <= pos;
        s0_first <= (pos == '0);
        s0_last  <= pos_is_last | in_last;
      end
    end
  end

  assign q_y_in  = s0_y;
  assign q_cb_in = s0_cb;
  assign q_cr_in = s0_cr;
  assign q_x     = s0_pos[5:3];
  assign q_y     = s0_pos[2:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      out_y     <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
    end else if (flush) begin
      s1_vld <= 1'b0;
    end else if (s1_load) begin
      s1_vld    <= 1'b1;
      out_y     <= q_y_out;
      out_cb    <= q_cb_out;
      out_cr    <= q_cr_out;
      out_first <= s0_first;
      out_last  <= s0_last;
    end else if (out_ready) begin
      s1_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)                blk_cnt <= '0;
    else if (out_fire && out_last) blk_cnt <= blk_cnt + 1'b1;
  end

  // A new misalignment in the same cycle as err_clr must not be lost.
  always_ff @(posedge clk) begin
    if (reset)          sync_err <= 1'b0;
    else if (align_err) sync_err <= 1'b1;
    else if (err_clr)   sync_err <= 1'b0;
  end
endmodule

// File: tb/tb_quant_ctrl.sv
// Scoreboard bench for quant_ctrl with a behavioural quantizer stand-in.
module tb_quant_ctrl;
  localparam int CW    = 14;
  localparam int QW    = 10;
  localparam int BLK_W = 16;

  logic                 clk, reset, flush, err_clr, in_valid, in_last, out_ready;
  logic                 in_ready, q_reset, out_valid, out_first, out_last, sync_err;
  logic signed [CW-1:0] in_y, in_cb, in_cr, q_y_in, q_cb_in, q_cr_in;
  logic [2:0]           q_x, q_y;
  logic [QW-1:0]        q_y_out, q_cb_out, q_cr_out, out_y, out_cb, out_cr;
  logic [BLK_W-1:0]     blk_cnt;

  quant_ctrl #(.CW(CW), .QW(QW), .BLK_W(BLK_W)) dut (
    .clk(clk), .reset(reset), .flush(flush), .err_clr(err_clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_y(in_y), .in_cb(in_cb), .in_cr(in_cr), .in_last(in_last),
    .q_reset(q_reset), .q_y_in(q_y_in), .q_cb_in(q_cb_in), .q_cr_in(q_cr_in),
    .q_x(q_x), .q_y(q_y),
    .q_y_out(q_y_out), .q_cb_out(q_cb_out), .q_cr_out(q_cr_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_cb(out_cb), .out_cr(out_cr),
    .out_first(out_first), .out_last(out_last),
    .blk_cnt(blk_cnt), .sync_err(sync_err)
  );

  typedef struct {
    logic [QW-1:0] y, cb, cr;
    logic          first, last;
    int            cyc;
  } exp_t;

  exp_t             sb[$];
  int               n_checks, n_errors, cyc, m_pos;
  logic             m_err;
  logic [BLK_W-1:0] m_blk;
  bit               m_run, acc, lat_chk, rdy_mode, prev_stall;
  logic [63:0]      prev_out;
  logic [3:0]       pat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [QW-1:0] qf(input logic signed [CW-1:0] d, input logic [5:0] idx, input int ch);
    logic signed [CW-1:0] ix, r;
    ix = $signed({{(CW-6){1'b0}}, idx});
    case (ch)
      0:       r = (d >>> 1) + ix;
      1:       r = d ^ ix;
      default: r = d - ix;
    endcase
    return r[QW-1:0];
  endfunction

  always_comb begin
    q_y_out  = qf(q_y_in,  {q_x, q_y}, 0);
    q_cb_out = qf(q_cb_in, {q_x, q_y}, 1);
    q_cr_out = qf(q_cr_in, {q_x, q_y}, 2);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called once per cycle just before the rising edge, with inputs already settled.
  task automatic evaluate();
    exp_t e;
    bit   set;
    acc = 0;
    set = 0;
    check("q_reset", 64'(q_reset), 64'(reset || !m_run));
    if (reset || !m_run || flush)   check("in_ready_low", 64'(in_ready), 64'd0);
    else if (!out_valid || out_ready) check("in_ready_high", 64'(in_ready), 64'd1);
    check("sync_err", 64'(sync_err), 64'(m_err));
    check("blk_cnt", 64'(blk_cnt), 64'(m_blk));
    if (prev_stall)
      check("stall_hold", {31'd0, out_valid, out_y, out_cb, out_cr, out_first, out_last}, prev_out);
    if (reset) begin
      sb.delete();
      m_pos = 0; m_err = 1'b0; m_blk = '0; m_run = 0; prev_stall = 0;
      return;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        check("out_y", 64'(out_y), 64'(e.y));
        check("out_cb", 64'(out_cb), 64'(e.cb));
        check("out_cr", 64'(out_cr), 64'(e.cr));
        check("out_flags", 64'({out_first, out_last}), 64'({e.first, e.last}));
        if (lat_chk) check("latency", 64'(cyc - e.cyc), 64'd2);
        if (e.last) m_blk = m_blk + 1'b1;
      end
    end
    if (flush) begin
      sb.delete();
      m_pos = 0;
    end
    if (in_valid && in_ready) begin
      acc     = 1;
      e.y     = qf(in_y,  6'(m_pos), 0);
      e.cb    = qf(in_cb, 6'(m_pos), 1);
      e.cr    = qf(in_cr, 6'(m_pos), 2);
      e.first = (m_pos == 0);
      e.last  = (m_pos == 63) || in_last;
      e.cyc   = cyc;
      sb.push_back(e);
      set   = (in_last != (m_pos == 63));
      m_pos = in_last ? 0 : (m_pos + 1) % 64;
    end
    if (set)          m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
    m_run      = 1;
    prev_stall = out_valid && !out_ready && !flush;
    prev_out   = {31'd0, out_valid, out_y, out_cb, out_cr, out_first, out_last};
  endtask

  task automatic tick();
    if (rdy_mode) out_ready = pat[cyc % 4];
    #1;
    evaluate();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send_beat(input logic signed [CW-1:0] y, input logic signed [CW-1:0] cb,
                           input logic signed [CW-1:0] cr, input logic last);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_y     = y;
    in_cb    = cb;
    in_cr    = cr;
    in_last  = last;
    do begin
      tick();
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("accept_timeout", 64'(acc), 64'd1);
    in_last = 1'b0;
  endtask

  // Every block starts at position 0, so beat k must sit in S0 at index k right after acceptance.
  task automatic send_block(input int n, input int last_at, input int seed);
    for (int k = 0; k < n; k++) begin
      send_beat(CW'(seed + k), CW'(-3 * k), CW'($urandom_range(0, 16383)), k == last_at);
      check("q_index", 64'({q_x, q_y}), 64'(k[5:0]));
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    while (sb.size() > 0 && guard < 500) begin
      tick();
      guard++;
    end
    check("drain", 64'(sb.size()), 64'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'({out_y, out_cb, out_cr, out_first, out_last}), 64'd0);
    check("rst_blk_cnt", 64'(blk_cnt), 64'd0);
    check("rst_sync_err", 64'(sync_err), 64'd0);
    check("rst_q_index", 64'({q_x, q_y}), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0; m_pos = 0; m_err = 1'b0; m_blk = '0;
    m_run = 0; acc = 0; lat_chk = 0; rdy_mode = 0; prev_stall = 0; prev_out = '0;
    pat = 4'b1001;
    reset = 1'b1; flush = 1'b0; err_clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; in_y = '0; in_cb = '0; in_cr = '0;
    @(posedge clk);
    @(negedge clk);

    // Reset release and one clean block at full rate.
    tick(); tick();
    check_reset_outputs();
    reset = 1'b0;
    #1;
    check("init_q_reset", 64'(q_reset), 64'd1);
    check("init_in_ready", 64'(in_ready), 64'd0);
    tick();
    #1;
    check("run_q_reset", 64'(q_reset), 64'd0);
    check("run_in_ready", 64'(in_ready), 64'd1);
    lat_chk = 1;
    send_block(64, 63, 0);
    drain();
    lat_chk = 0;
    check("blk_after_first", 64'(blk_cnt), 64'd1);

    // Back-pressure with out_ready 1,0,0,1.
    rdy_mode = 1;
    send_block(64, 63, 500);
    send_block(64, 63, -700);
    send_block(64, 63, 1234);
    drain();
    rdy_mode  = 0;
    out_ready = 1'b1;
    check("blk_after_bp", 64'(blk_cnt), 64'd4);

    // Early last on beat 40, then clear.
    send_block(41, 40, 42);
    idle(3);
    check("early_err", 64'(sync_err), 64'd1);
    check("blk_after_early", 64'(blk_cnt), 64'd5);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", 64'(sync_err), 64'd0);
    send_block(64, 63, 77);

    // Missing last on beat 63, with err_clr in the same cycle.
    send_block(63, -1, 300);
    err_clr = 1'b1;
    send_beat(CW'(-5), CW'(9), CW'(11), 1'b0);
    err_clr = 1'b0;
    check("set_beats_clr", 64'(sync_err), 64'd1);
    send_block(64, 63, 900);
    drain();
    check("missing_err", 64'(sync_err), 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;

    // Flush at beat 20 with both stages full.
    send_block(20, -1, 2000);
    out_ready = 1'b0;
    send_block(0, -1, 0);
    in_valid = 1'b1;
    in_y     = CW'(20);
    tick();
    check("full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_blk_cnt", 64'(blk_cnt), 64'(m_blk));
    out_ready = 1'b1;
    send_block(64, 63, -3000);
    drain();

    // Reset in the middle of a block.
    send_block(30, -1, 4000);
    reset = 1'b1;
    tick(); tick();
    check_reset_outputs();
    reset = 1'b0;
    #1;
    check("reinit_q_reset", 64'(q_reset), 64'd1);
    check("reinit_in_ready", 64'(in_ready), 64'd0);
    tick();
    send_block(64, 63, 555);
    drain();
    check("blk_after_reset", 64'(blk_cnt), 64'd1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
